// File: rtl/ws2812_pkg.sv
// Shared types, row colours and timing helper for the WS2812 bar-matrix transmitter.
package ws2812_pkg;

  typedef enum logic [1:0] {
    ST_GAP  = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2
  } state_e;

  localparam int unsigned N_PIX        = 64;
  localparam int unsigned BITS_PER_PIX = 24;

  // GRB colour per row, row 0 at the bottom: green, then yellow, then red at the top.
  localparam logic [23:0] ROW_GRB [8] = '{
    24'h200000, 24'h200000, 24'h200000,
    24'h202000, 24'h202000, 24'h202000,
    24'h002000, 24'h002000
  };

  // Truncating conversion; the product is 64-bit so RESET_US*1000 at high clock rates cannot overflow.
  function automatic int unsigned ns_to_cycles(input longint unsigned clk_hz,
                                               input longint unsigned ns);
    return 32'((clk_hz / 64'd1000) * ns / 64'd1_000_000);
  endfunction

endpackage

// File: rtl/ws2812_bit_tx.sv
// Single-bit WS2812 waveform generator: one high/low period per accepted bit.
module ws2812_bit_tx #(
  parameter int unsigned T0H  = 20,
  parameter int unsigned T1H  = 40,
  parameter int unsigned TBIT = 62
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic bit_valid,
  input  logic bit_val,
  output logic bit_ready,
  output logic near_end_c,
  output logic dout_o
);

  localparam int unsigned PW = $clog2(TBIT);
  localparam logic [PW-1:0] PHASE_PRE_LAST = PW'(TBIT - 2);

  logic          active_q;
  logic [PW-1:0] phase_q;
  logic          dout_q;
  logic          bit_ready_q;

  logic [PW-1:0] phase_nx_c;
  logic [PW-1:0] hi_len_c;
  logic          start_c;

  // bit_val is only consulted after the first high cycle, so it may settle during phase 0.
  assign phase_nx_c = phase_q + PW'(1);
  assign hi_len_c   = bit_val ? PW'(T1H) : PW'(T0H);
  assign start_c    = bit_valid && (!active_q || bit_ready_q);
  assign near_end_c = active_q && (phase_q == PHASE_PRE_LAST);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      active_q    <= 1'b0;
      phase_q     <= '0;
      dout_q      <= 1'b0;
      bit_ready_q <= 1'b0;
    end else begin
      bit_ready_q <= near_end_c;
      if (start_c) begin
        active_q <= 1'b1;
        phase_q  <= '0;
        dout_q   <= 1'b1;
      end else if (bit_ready_q) begin
        active_q <= 1'b0;
        phase_q  <= '0;
        dout_q   <= 1'b0;
      end else if (active_q) begin
        phase_q  <= phase_nx_c;
        dout_q   <= (phase_nx_c < hi_len_c);
      end
    end
  end

  assign bit_ready = bit_ready_q;
  assign dout_o    = dout_q;

endmodule

// File: rtl/ws2812_bar_tx.sv
// Frame FSM, bar snapshot and pixel mapping for an 8x8 WS2812 spectrum display.
// Define WS2812_SERPENTINE_EN for zig-zag wired matrices (odd rows reversed).
module ws2812_bar_tx
  import ws2812_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned T0H_NS      = 400,
  parameter int unsigned T1H_NS      = 800,
  parameter int unsigned TBIT_NS     = 1250,
  parameter int unsigned RESET_US    = 300
) (
  input  logic            sys_clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic [7:0][7:0] bar_data,
  output logic            ws_dout,
  output logic            busy,
  output logic            frame_done
);

  localparam int unsigned T0H_CYC   = ns_to_cycles(64'(CLK_FREQ_HZ), 64'(T0H_NS));
  localparam int unsigned T1H_CYC   = ns_to_cycles(64'(CLK_FREQ_HZ), 64'(T1H_NS));
  localparam int unsigned TBIT_CYC  = ns_to_cycles(64'(CLK_FREQ_HZ), 64'(TBIT_NS));
  localparam int unsigned RESET_CYC = ns_to_cycles(64'(CLK_FREQ_HZ), 64'(RESET_US) * 64'd1000);
  localparam int unsigned GW        = $clog2(RESET_CYC + 1);

  state_e          state_q;
  logic [GW-1:0]   gap_q;
  logic [7:0][7:0] snap_q;
  logic [5:0]      pix_q;
  logic [4:0]      bit_q;
  logic            busy_q;
  logic            frame_done_q;

  logic [2:0]  row_c;
  logic [2:0]  col_c;
  logic [23:0] word_c;
  logic        bit_val_c;
  logic        last_bit_c;
  logic        bit_valid_c;
  logic        gap_done_c;
  logic        bit_ready;
  logic        near_end_c;

  assign row_c = pix_q[5:3];
`ifdef WS2812_SERPENTINE_EN
  assign col_c = row_c[0] ? ~pix_q[2:0] : pix_q[2:0];
`else
  assign col_c = pix_q[2:0];
`endif

  assign word_c      = snap_q[col_c][row_c] ? ROW_GRB[row_c] : 24'h000000;
  assign bit_val_c   = word_c[5'd23 - bit_q];
  assign last_bit_c  = (pix_q == 6'(N_PIX - 1)) && (bit_q == 5'(BITS_PER_PIX - 1));
  assign gap_done_c  = (gap_q >= GW'(RESET_CYC - 1));
  // LOAD kicks off bit 0; the final bit is offered without a successor so the line idles low.
  assign bit_valid_c = (state_q == ST_LOAD) || ((state_q == ST_SEND) && !last_bit_c);

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q      <= ST_GAP;
      gap_q        <= '0;
      snap_q       <= '0;
      pix_q        <= '0;
      bit_q        <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= (state_q == ST_SEND) && last_bit_c && near_end_c;
      case (state_q)
        ST_GAP: begin
          if (gap_q != GW'(RESET_CYC)) gap_q <= gap_q + GW'(1);
          if (gap_done_c && enable) begin
            state_q <= ST_LOAD;
            busy_q  <= 1'b1;
          end
        end
        ST_LOAD: begin
          snap_q  <= bar_data;
          pix_q   <= '0;
          bit_q   <= '0;
          state_q <= ST_SEND;
        end
        ST_SEND: begin
          if (bit_ready) begin
            if (last_bit_c) begin
              state_q <= ST_GAP;
              gap_q   <= '0;
              busy_q  <= 1'b0;
            end else if (bit_q == 5'(BITS_PER_PIX - 1)) begin
              bit_q <= '0;
              pix_q <= pix_q + 6'd1;
            end else begin
              bit_q <= bit_q + 5'd1;
            end
          end
        end
        default: state_q <= ST_GAP;
      endcase
    end
  end

  ws2812_bit_tx #(
    .T0H  (T0H_CYC),
    .T1H  (T1H_CYC),
    .TBIT (TBIT_CYC)
  ) u_bit_tx (
    .clk_i      (sys_clk),
    .rst_ni     (rst_n),
    .bit_valid  (bit_valid_c),
    .bit_val    (bit_val_c),
    .bit_ready  (bit_ready),
    .near_end_c (near_end_c),
    .dout_o     (ws_dout)
  );

  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ws2812_bar_tx.sv
// Directed bench for ws2812_bar_tx with a pulse-width scoreboard; honours WS2812_SERPENTINE_EN.
module tb_ws2812_bar_tx;

  // 5 MHz gives T0H=2, T1H=4, TBIT=6 and, with RESET_US=20, a 100-cycle gap.
  localparam int unsigned CLK_HZ = 5_000_000;
  localparam int unsigned T0H    = 2;
  localparam int unsigned T1H    = 4;
  localparam int unsigned TBIT   = 6;
  localparam int unsigned RST    = 100;
  localparam int unsigned NBITS  = 1536;
  localparam int unsigned FRAME  = NBITS * TBIT;
`ifdef WS2812_SERPENTINE_EN
  localparam bit SERP = 1'b1;
`else
  localparam bit SERP = 1'b0;
`endif
  localparam logic [23:0] ROW [8] = '{
    24'h200000, 24'h200000, 24'h200000,
    24'h202000, 24'h202000, 24'h202000,
    24'h002000, 24'h002000
  };

  logic            sys_clk = 1'b0;
  logic            rst_n;
  logic            enable;
  logic [7:0][7:0] bar_data;
  logic            ws_dout;
  logic            busy;
  logic            frame_done;

  always #5 sys_clk = ~sys_clk;

  ws2812_bar_tx #(
    .CLK_FREQ_HZ (CLK_HZ),
    .T0H_NS      (400),
    .T1H_NS      (800),
    .TBIT_NS     (1250),
    .RESET_US    (20)
  ) dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .bar_data   (bar_data),
    .ws_dout    (ws_dout),
    .busy       (busy),
    .frame_done (frame_done)
  );

  int     tests = 0;
  int     fails = 0;
  longint cyc = 0;
  longint last_rise = 0;
  int     exp_q[$];
  logic   prev = 1'b0;
  int     nbits = 0;
  int     rises = 0;
  int     done_cnt = 0;
  bit     rose = 1'b0;
  bit     done_seen = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Expected high time of every bit in a frame, in transmit order.
  task automatic push_frame(input logic [7:0][7:0] bd);
    for (int p = 0; p < 64; p++) begin
      int          row;
      int          col;
      logic [23:0] w;
      row = p / 8;
      col = p % 8;
      if (SERP && (row % 2 == 1)) col = 7 - col;
      w = bd[col][row] ? ROW[row] : 24'h000000;
      for (int b = 23; b >= 0; b--) exp_q.push_back(w[b] ? int'(T1H) : int'(T0H));
    end
  endtask

  // One clock, sampled on the falling edge, with the line monitor folded in.
  task automatic step();
    int want;
    @(negedge sys_clk);
    cyc++;
    rose      = 1'b0;
    done_seen = 1'b0;
    if (!rst_n) begin
      nbits = 0;
      prev  = ws_dout;
    end else begin
      if (ws_dout && !prev) begin
        if (nbits > 0) check("bit_period", 64'(cyc - last_rise), 64'(TBIT));
        last_rise = cyc;
        nbits++;
        rises++;
        rose = 1'b1;
      end
      if (!ws_dout && prev) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        check("pulse_width", 64'(cyc - last_rise), 64'(want));
      end
      if (frame_done) begin
        done_cnt++;
        done_seen = 1'b1;
        check("done_bits", 64'(nbits), 64'(NBITS));
        check("done_phase", 64'(cyc - last_rise), 64'(TBIT - 1));
        nbits = 0;
      end
      prev = ws_dout;
    end
  endtask

  task automatic wait_rise(output int n, input int limit);
    n = 0;
    while (n < limit) begin
      step();
      n++;
      if (rose) break;
    end
  endtask

  task automatic wait_done(output int n, input int limit);
    n = 0;
    while (n < limit) begin
      step();
      n++;
      if (done_seen) break;
    end
  endtask

  task automatic wait_bits(input int target, input int limit);
    int n;
    n = 0;
    while ((n < limit) && (nbits < target)) begin
      step();
      n++;
    end
  endtask

  initial begin
    int              n;
    int              r0;
    logic [7:0][7:0] bd;

    rst_n    = 1'b0;
    enable   = 1'b1;
    bar_data = '0;
    repeat (3) step();
    check("rst_dout", 64'(ws_dout), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(frame_done), 64'(0));

    // Idle frame straight out of reset
    push_frame(bar_data);
    rst_n = 1'b1;
    wait_rise(n, RST + 50);
    check("first_rise", 64'(n), 64'(RST + 1));
    check("busy_sending", 64'(busy), 64'(1));
    wait_done(n, FRAME + 50);
    check("frame_len_idle", 64'(n), 64'(FRAME - 1));
    check("busy_at_done", 64'(busy), 64'(1));
    check("queue_idle", 64'(exp_q.size()), 64'(0));
    step();
    check("done_one_cycle", 64'(frame_done), 64'(0));
    check("busy_fall", 64'(busy), 64'(0));

    // Single lit pixel at column 0, row 0
    bd       = '0;
    bd[0]    = 8'h01;
    bar_data = bd;
    push_frame(bd);
    wait_rise(n, RST + 50);
    check("gap_len", 64'(n), 64'(RST + 1));
    wait_done(n, FRAME + 50);
    check("frame_len_single", 64'(n), 64'(FRAME - 1));
    check("queue_single", 64'(exp_q.size()), 64'(0));
    step();

    // Row-1 pixel (wiring order) and snapshot isolation across a mid-frame change
    bd       = '0;
    bd[0][1] = 1'b1;
    bar_data = bd;
    push_frame(bd);
    bd = '1;
    push_frame(bd);
    wait_rise(n, RST + 50);
    check("gap_len_serp", 64'(n), 64'(RST + 1));
    wait_bits(100, FRAME);
    check("reached_bit100", 64'(nbits), 64'(100));
    bar_data = '1;
    wait_done(n, FRAME + 50);
    check("queue_old_snapshot", 64'(exp_q.size()), 64'(NBITS));
    step();

    // All-lit frame; enable dropped mid-frame must not truncate it
    wait_rise(n, RST + 50);
    check("gap_len_lit", 64'(n), 64'(RST + 1));
    wait_bits(200, FRAME);
    enable = 1'b0;
    wait_done(n, FRAME + 50);
    check("queue_lit", 64'(exp_q.size()), 64'(0));
    r0 = rises;
    repeat (3 * RST) step();
    check("no_rise_disabled", 64'(rises - r0), 64'(0));
    check("busy_disabled", 64'(busy), 64'(0));
    enable = 1'b1;
    wait_rise(n, 10);
    check("enable_load", 64'(n), 64'(2));

    // Reset while the line is high
    check("dout_high_pre_rst", 64'(ws_dout), 64'(1));
    rst_n = 1'b0;
    step();
    check("rst_mid_dout", 64'(ws_dout), 64'(0));
    check("rst_mid_busy", 64'(busy), 64'(0));
    exp_q.delete();
    bd       = '0;
    bd[5]    = 8'hA5;
    bd[2]    = 8'h3C;
    bar_data = bd;
    push_frame(bd);
    rst_n = 1'b1;
    wait_rise(n, RST + 50);
    check("post_rst_gap", 64'(n), 64'(RST + 1));
    wait_done(n, FRAME + 50);
    check("frame_len_post_rst", 64'(n), 64'(FRAME - 1));
    check("queue_post_rst", 64'(exp_q.size()), 64'(0));
    check("done_count", 64'(done_cnt), 64'(5));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ws2812_bar_tx.md
# ws2812_bar_tx

Drives an 8x8 WS2812 LED matrix from the 8-column bar-level vector produced by the FFT bar quantiser. It snapshots `bar_data` once per frame, maps each column/row bit to a pixel colour, and serialises 64 GRB pixels on the single-wire WS2812 protocol, followed by a latch gap. It is the LED-side consumer of the spectrum display chain.

## Interface
- `CLK_FREQ_HZ`, 50_000_000: `sys_clk` frequency.
- `T0H_NS`, 400: high time of a 0 bit.
- `T1H_NS`, 800: high time of a 1 bit.
- `TBIT_NS`, 1250: full bit period.
- `RESET_US`, 300: low latch gap between frames.
- `sys_clk` in 1: the single clock.
- `rst_n` in 1: synchronous, active-low reset.
- `enable` in 1: permits starting a new frame.
- `bar_data` in [7:0][7:0]: `bar_data[c][r]` = 1 means column c, row r is lit. Row 0 is the bottom row.
- `ws_dout` out 1: WS2812 serial data.
- `busy` out 1: high from LOAD through the last bit of SEND.
- `frame_done` out 1: one-cycle pulse when the last bit period ends.

## Operation
- Cycle constants use integer truncation: `N = CLK_FREQ_HZ/1000 * ns / 1_000_000`. At 50 MHz this gives T0H=20, T1H=40, TBIT=62 and RESET=15000 cycles.
- The state machine has three states: GAP, LOAD and SEND.
- GAP:
  - `ws_dout` = 0 and a counter counts RESET cycles.
  - When the count is reached and `enable` = 1, go to LOAD.
  - If `enable` = 0, hold in GAP with the counter saturated.
- LOAD (1 cycle): latch `bar_data` into an internal snapshot, clear the pixel and bit indices, then go to SEND.
- SEND:
  - Pixel p = 0..63: row = p/8, col = p%8.
  - The pixel word is `ROW_GRB[row]` if `snap[col][row]`, else 24'h000000.
  - Bits go MSB first (G[7] first).
  - Each bit drives `ws_dout` = 1 for T0H or T1H cycles, then 0 for the rest of TBIT.
- After bit 23 of pixel 63 completes: `frame_done` = 1 for that cycle, state returns to GAP and the counter clears.
- `bar_data` is sampled only in LOAD. Changes during SEND and GAP have no effect on the current frame.
- `enable` is sampled only at the GAP exit. Deasserting it mid-frame never truncates a frame.
- Arithmetic:
  - Bit-phase counter width is `$clog2(TBIT)`.
  - Gap counter width is `$clog2(RESET+1)`.
  - Pixel index is 6 bits; bit index is 5 bits (0..23).

## Timing
- Reset values: `ws_dout` = 0, `busy` = 0, `frame_done` = 0, state GAP with counter 0, snapshot all 0.
- Reset asserted mid-operation: on the next edge `ws_dout` = 0 and `busy` = 0. The full RESET gap restarts after release, so the strip sees a valid latch.
- First frame: LOAD is entered RESET cycles after the first cycle with `rst_n` = 1 (cycle 15000 at 50 MHz).
- The first `ws_dout` rise is on the cycle after LOAD.
- The frame lasts 1536 × TBIT = 95232 cycles.
- `frame_done` is asserted on the final cycle of bit 1535. `busy` falls on the following cycle.
- Frame period with `enable` held high: RESET + 1 + 1536·TBIT.
- `ws_dout` is registered, with no combinational path from inputs.

## Configuration
- `WS2812_SERPENTINE_EN` defined: matrix wiring is zig-zag. On odd rows the column order is reversed (col = 7 − p%8).
- `WS2812_SERPENTINE_EN` undefined: every row is left-to-right (col = p%8).
- Nothing else changes.

## Structure
- Package `ws2812_pkg` holds:
  - `ROW_GRB[8]`, 24-bit colours: rows 0–2 green, 3–5 yellow, 6–7 red.
  - The state enum.
  - The `ns_to_cycles` function.
- Sub-module `ws2812_bit_tx`:
  - Takes one bit at a time (`bit_valid` / `bit_ready` / `bit_val`).
  - Generates the high/low waveform.
  - Asserts `bit_ready` for one cycle at the end of each period.
  - The top level owns the frame FSM, snapshot and pixel mapping.

## Test plan
- **Idle frame:** release reset with `bar_data` = 0 and `enable` = 1 → `ws_dout` low for 15000 cycles, then 1536 pulses each 20 high / 42 low. `frame_done` pulses at cycle 15001+95232−1.
- **Single bit:** `bar_data[0]` = 8'h01 → pixel 0 = `ROW_GRB[0]` with 1 bits high for 40 cycles. Pixels 1–63 are all-zero pulses.
- **Serpentine mapping:** `bar_data[0][1]` = 1 → lit pixel is index 15 with `WS2812_SERPENTINE_EN`, index 8 without.
- **Snapshot isolation:** change `bar_data` to 8'hFF everywhere at bit 100 → current frame matches the old snapshot; the next frame is all lit.
- **Reset mid-bit:** assert `rst_n` = 0 while `ws_dout` is high → next edge `ws_dout` = 0, `busy` = 0. After release, no rise for 15000 cycles.
- **Enable gating:** drop `enable` mid-SEND → frame completes and `frame_done` pulses, then the line stays low indefinitely. Raising `enable` after more than 15000 cycles → LOAD on the next cycle.
